gerenciador_elevador_param: RTL and testbench

Parametrised single-car elevator controller: a request FIFO of (origem, destino) pairs, a current-floor register, a per-floor travel timer, a door timer, and a service FSM. Each request is served in arrival order: travel to origem, open the door, travel to destino, open the door. It replaces the fixed 4-bit, depth-16, untimed stop-queue datapath. It adds these features:

- Configurable floor count and queue depth.
- Request validation.
- Overflow reporting.
- Direction reporting.
- Timed movement and door phases.

---
 rtl/elevador_pkg.sv | 27 ++
 rtl/fila_pedidos.sv | 62 ++++++
 rtl/gerenciador_elevador_param.sv | 152 +++++++++++++++
 tb/tb_gerenciador_elevador_param.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// Shared types and helpers for the parametrised elevator controller.
package elevador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CARREGA,
    ST_MOVE_ORIGEM,
    ST_PORTA_ORIGEM,
    ST_MOVE_DESTINO,
    ST_PORTA_DESTINO
  } estado_t;

  localparam logic [1:0] DIR_PARADO = 2'b00;
  localparam logic [1:0] DIR_SOBE   = 2'b01;
  localparam logic [1:0] DIR_DESCE  = 2'b10;

  // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fila_pedidos.sv
// Synchronous request FIFO, first-word-fall-through, with occupancy flags.
module fila_pedidos
  import elevador_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW    = clog2(DEPTH),
  localparam int unsigned OCC_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_dado,
  output logic [WIDTH-1:0] o_cabeca_c,
  output logic             o_vazia,
  output logic             o_cheia,
  output logic [OCC_W-1:0] o_ocupacao
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [OCC_W-1:0] r_count, w_count_n;
  logic             r_vazia, r_cheia;
  logic             w_pop, w_push;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop  = i_pop && !r_vazia;
  assign w_push = i_push && (!r_cheia || w_pop);

  always_comb begin
    w_count_n = r_count;
    if (w_push && !w_pop)      w_count_n = r_count + OCC_W'(1);
    else if (w_pop && !w_push) w_count_n = r_count - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_dado;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_vazia <= 1'b1;
      r_cheia <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= w_count_n;
      r_vazia <= (w_count_n == '0);
      r_cheia <= (w_count_n == OCC_W'(DEPTH));
    end
  end

  assign o_cabeca_c = r_mem[r_rd];
  assign o_vazia    = r_vazia;
  assign o_cheia    = r_cheia;
  assign o_ocupacao = r_count;

endmodule

// File: rtl/gerenciador_elevador_param.sv
// Single-car elevator controller: serves queued (origem, destino) requests in
// arrival order with timed floor travel and door phases.
module gerenciador_elevador_param
  import elevador_pkg::*;
#(
  parameter int unsigned N_FLOORS      = 16,
  parameter int unsigned FILA_DEPTH    = 8,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 8,
  localparam int unsigned FLOOR_W = (clog2(N_FLOORS) >= 1) ? clog2(N_FLOORS) : 1,
  localparam int unsigned OCC_W   = clog2(FILA_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pedido,
  input  logic [FLOOR_W-1:0] origem,
  input  logic [FLOOR_W-1:0] destino,
  output logic [FLOOR_W-1:0] andarAtual,
  output logic [FLOOR_W-1:0] proxParada,
  output logic [1:0]         direcao,
  output logic               porta_aberta,
  output logic               ocupado,
  output logic               fila_vazia,
  output logic               fila_cheia,
  output logic [OCC_W-1:0]   ocupacao,
  output logic               rejeitado
);

  localparam int unsigned TW = (clog2(TRAVEL_CYCLES) >= 1) ? clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DW = (clog2(DOOR_CYCLES) >= 1) ? clog2(DOOR_CYCLES) : 1;

  estado_t              r_estado, w_estado_n;
  logic [FLOOR_W-1:0]   r_andar, w_andar_n;
  logic [FLOOR_W-1:0]   r_alvo_o, w_alvo_o_n, r_alvo_d, w_alvo_d_n;
  logic [FLOOR_W-1:0]   w_alvo, r_prox, w_prox_n;
  logic [TW-1:0]        r_t_mov, w_t_mov_n;
  logic [DW-1:0]        r_t_porta, w_t_porta_n;
  logic [1:0]           r_dir, w_dir_n;
  logic                 r_porta, r_ocupado, r_rej, r_pedido_prev, r_armado;
  logic                 w_evento, w_valido, w_pop, w_push;
  logic [2*FLOOR_W-1:0] w_cab;

  // r_armado masks the first cycle after reset so a level held through reset is not a request.
  assign w_evento = pedido && !r_pedido_prev && r_armado;
  assign w_valido = (32'(origem) < N_FLOORS) && (32'(destino) < N_FLOORS) && (origem != destino);
  assign w_pop    = (r_estado == ST_CARREGA);
  assign w_push   = w_evento && w_valido && (!fila_cheia || w_pop);

  fila_pedidos #(
    .WIDTH (2 * FLOOR_W),
    .DEPTH (FILA_DEPTH)
  ) u_fila (
    .clk        (clock),
    .rst_n      (reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_dado     ({origem, destino}),
    .o_cabeca_c (w_cab),
    .o_vazia    (fila_vazia),
    .o_cheia    (fila_cheia),
    .o_ocupacao (ocupacao)
  );

  assign w_alvo = (r_estado == ST_MOVE_DESTINO || r_estado == ST_PORTA_DESTINO) ? r_alvo_d : r_alvo_o;

  always_comb begin
    w_estado_n  = r_estado;
    w_andar_n   = r_andar;
    w_alvo_o_n  = r_alvo_o;
    w_alvo_d_n  = r_alvo_d;
    w_t_mov_n   = r_t_mov;
    w_t_porta_n = r_t_porta;
    case (r_estado)
      ST_IDLE: if (!fila_vazia) w_estado_n = ST_CARREGA;
      ST_CARREGA: begin
        w_alvo_o_n = w_cab[2*FLOOR_W-1:FLOOR_W];
        w_alvo_d_n = w_cab[FLOOR_W-1:0];
        w_estado_n = ST_MOVE_ORIGEM;
      end
      ST_MOVE_ORIGEM, ST_MOVE_DESTINO: begin
        if (r_andar == w_alvo) begin
          w_t_mov_n  = '0;
          w_estado_n = (r_estado == ST_MOVE_ORIGEM) ? ST_PORTA_ORIGEM : ST_PORTA_DESTINO;
        end else if (r_t_mov == TW'(TRAVEL_CYCLES - 1)) begin
          w_t_mov_n = '0;
          w_andar_n = (w_alvo > r_andar) ? r_andar + FLOOR_W'(1) : r_andar - FLOOR_W'(1);
        end else begin
          w_t_mov_n = r_t_mov + TW'(1);
        end
      end
      ST_PORTA_ORIGEM, ST_PORTA_DESTINO: begin
        if (r_t_porta == DW'(DOOR_CYCLES - 1)) begin
          w_t_porta_n = '0;
          w_estado_n  = (r_estado == ST_PORTA_ORIGEM) ? ST_MOVE_DESTINO : ST_IDLE;
        end else begin
          w_t_porta_n = r_t_porta + DW'(1);
        end
      end
      default: w_estado_n = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    case (w_estado_n)
      ST_MOVE_ORIGEM, ST_PORTA_ORIGEM:   w_prox_n = w_alvo_o_n;
      ST_MOVE_DESTINO, ST_PORTA_DESTINO: w_prox_n = w_alvo_d_n;
      default:                           w_prox_n = w_andar_n;
    endcase
    w_dir_n = DIR_PARADO;
    if ((w_estado_n == ST_MOVE_ORIGEM || w_estado_n == ST_MOVE_DESTINO) && (w_prox_n != w_andar_n))
      w_dir_n = (w_prox_n > w_andar_n) ? DIR_SOBE : DIR_DESCE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado      <= ST_IDLE;
      r_andar       <= '0;
      r_alvo_o      <= '0;
      r_alvo_d      <= '0;
      r_t_mov       <= '0;
      r_t_porta     <= '0;
      r_prox        <= '0;
      r_dir         <= DIR_PARADO;
      r_porta       <= 1'b0;
      r_ocupado     <= 1'b0;
      r_rej         <= 1'b0;
      r_pedido_prev <= 1'b0;
      r_armado      <= 1'b0;
    end else begin
      r_estado      <= w_estado_n;
      r_andar       <= w_andar_n;
      r_alvo_o      <= w_alvo_o_n;
      r_alvo_d      <= w_alvo_d_n;
      r_t_mov       <= w_t_mov_n;
      r_t_porta     <= w_t_porta_n;
      r_prox        <= w_prox_n;
      r_dir         <= w_dir_n;
      r_porta       <= (w_estado_n == ST_PORTA_ORIGEM) || (w_estado_n == ST_PORTA_DESTINO);
      r_ocupado     <= (w_estado_n != ST_IDLE);
      r_rej         <= w_evento && !w_push;
      r_pedido_prev <= pedido;
      r_armado      <= 1'b1;
    end
  end

  assign andarAtual   = r_andar;
  assign proxParada   = r_prox;
  assign direcao      = r_dir;
  assign porta_aberta = r_porta;
  assign ocupado      = r_ocupado;
  assign rejeitado    = r_rej;

endmodule

// File: tb/tb_gerenciador_elevador_param.sv
// Directed bench for gerenciador_elevador_param; door-opening floors are
// scoreboarded against the order in which requests were accepted.
module tb_gerenciador_elevador_param;

  localparam int unsigned NF = 12;
  localparam int unsigned FD = 8;
  localparam int unsigned TC = 4;
  localparam int unsigned DC = 8;
  localparam int unsigned FW = 4;
  localparam int unsigned OW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          pedido = 1'b0;
  logic [FW-1:0] origem = '0;
  logic [FW-1:0] destino = '0;
  logic [FW-1:0] andarAtual, proxParada;
  logic [1:0]    direcao;
  logic          porta_aberta, ocupado, fila_vazia, fila_cheia, rejeitado;
  logic [OW-1:0] ocupacao;

  int            n_cmp = 0;
  int            n_err = 0;
  int            np;
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] m_exp;
  logic          porta_prev = 1'b0;
  int            porta_len = 0;

  always #5 clock = ~clock;

  gerenciador_elevador_param #(
    .N_FLOORS      (NF),
    .FILA_DEPTH    (FD),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pedido       (pedido),
    .origem       (origem),
    .destino      (destino),
    .andarAtual   (andarAtual),
    .proxParada   (proxParada),
    .direcao      (direcao),
    .porta_aberta (porta_aberta),
    .ocupado      (ocupado),
    .fila_vazia   (fila_vazia),
    .fila_cheia   (fila_cheia),
    .ocupacao     (ocupacao),
    .rejeitado    (rejeitado)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_andar"},   32'(andarAtual),   32'd0);
    chk({tag, "_prox"},    32'(proxParada),   32'd0);
    chk({tag, "_dir"},     32'(direcao),      32'd0);
    chk({tag, "_porta"},   32'(porta_aberta), 32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado),      32'd0);
    chk({tag, "_rej"},     32'(rejeitado),    32'd0);
    chk({tag, "_vazia"},   32'(fila_vazia),   32'd1);
    chk({tag, "_cheia"},   32'(fila_cheia),   32'd0);
    chk({tag, "_ocup"},    32'(ocupacao),     32'd0);
  endtask

  // Rising edge of pedido is sampled at the first tick; returns one cycle later.
  task automatic send(input int o, input int d, input logic exp_rej);
    origem  = FW'(o);
    destino = FW'(d);
    pedido  = 1'b1;
    tick();
    chk("rejeitado", 32'(rejeitado), 32'(exp_rej));
    if (!exp_rej) begin
      exp_q.push_back(FW'(o));
      exp_q.push_back(FW'(d));
    end
    pedido = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(ocupado === 1'b0 && fila_vazia === 1'b1) && n < budget) begin tick(); n++; end
    chk("timeout_idle", 32'(n >= budget), 32'd0);
  endtask

  task automatic wait_livre(input int budget);
    int n = 0;
    while (ocupado !== 1'b0 && n < budget) begin tick(); n++; end
    chk("timeout_livre", 32'(n >= budget), 32'd0);
  endtask

  task automatic wait_porta(input logic v, input int budget);
    int n = 0;
    while (porta_aberta !== v && n < budget) begin tick(); n++; end
    chk("timeout_porta", 32'(n >= budget), 32'd0);
  endtask

  task automatic wait_andar(input int f, input int budget);
    int n = 0;
    while (32'(andarAtual) != 32'(f) && n < budget) begin tick(); n++; end
    chk("timeout_andar", 32'(n >= budget), 32'd0);
  endtask

  // Door monitor: every opening must happen at the next scoreboarded floor and last DC cycles.
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      porta_prev <= 1'b0;
      porta_len  <= 0;
    end else begin
      porta_prev <= porta_aberta;
      if (porta_aberta === 1'b1 && porta_prev === 1'b0) begin
        porta_len <= 1;
        if (exp_q.size() == 0) begin
          chk("porta_extra", 32'(andarAtual), 32'hFFFF_FFFF);
        end else begin
          m_exp = exp_q.pop_front();
          chk("porta_andar", 32'(andarAtual), 32'(m_exp));
        end
      end else if (porta_aberta === 1'b1) begin
        porta_len <= porta_len + 1;
      end else if (porta_prev === 1'b1) begin
        chk("porta_ciclos", 32'(porta_len), DC);
      end
    end
  end

  initial begin
    reset = 1'b0;
    tick(); tick();
    chk_reset("rst");
    reset = 1'b1;
    tick(); tick();

    // 0 -> 3 with exact timing
    send(0, 3, 1'b0);
    chk("t1_ocupado", 32'(ocupado), 32'd1);
    chk("t1_ocup", 32'(ocupacao), 32'd1);
    tick();
    chk("t1_vazia", 32'(fila_vazia), 32'd1);
    chk("t1_prox0", 32'(proxParada), 32'd0);
    tick();
    chk("t1_porta_on", 32'(porta_aberta), 32'd1);
    chk("t1_dir_door", 32'(direcao), 32'd0);
    repeat (8) tick();
    chk("t1_porta_off", 32'(porta_aberta), 32'd0);
    chk("t1_dir_up", 32'(direcao), 32'd1);
    chk("t1_prox3", 32'(proxParada), 32'd3);
    repeat (4) tick();
    chk("t1_andar1", 32'(andarAtual), 32'd1);
    repeat (4) tick();
    chk("t1_andar2", 32'(andarAtual), 32'd2);
    repeat (4) tick();
    chk("t1_andar3", 32'(andarAtual), 32'd3);
    chk("t1_dir_arr", 32'(direcao), 32'd0);
    tick();
    chk("t1_porta2_on", 32'(porta_aberta), 32'd1);
    repeat (8) tick();
    chk("t1_porta2_off", 32'(porta_aberta), 32'd0);
    chk("t1_idle", 32'(ocupado), 32'd0);
    chk("t1_prox_idle", 32'(proxParada), 32'd3);

    // Move to 5, then 2 -> 7 (down then up)
    send(3, 5, 1'b0);
    wait_idle(400);
    chk("t2_at5", 32'(andarAtual), 32'd5);
    send(2, 7, 1'b0);
    tick();
    chk("t2_prox2", 32'(proxParada), 32'd2);
    chk("t2_dir_down", 32'(direcao), 32'd2);
    wait_porta(1'b1, 200);
    chk("t2_andar2", 32'(andarAtual), 32'd2);
    wait_porta(1'b0, 200);
    chk("t2_dir_up", 32'(direcao), 32'd1);
    chk("t2_prox7", 32'(proxParada), 32'd7);
    wait_idle(400);
    chk("t2_at7", 32'(andarAtual), 32'd7);

    // Invalid requests
    send(4, 4, 1'b1);
    chk("t3_rej_pulse", 32'(rejeitado), 32'd0);
    send(3, 12, 1'b1);
    send(15, 2, 1'b1);
    chk("t3_ocup", 32'(ocupacao), 32'd0);
    origem = 4'd5; destino = 4'd5; pedido = 1'b1;
    np = 0;
    repeat (10) begin tick(); np += 32'(rejeitado); end
    pedido = 1'b0;
    tick();
    chk("t3_held_pulses", 32'(np), 32'd1);
    origem = 4'd1; destino = 4'd2; pedido = 1'b1;
    tick();
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    repeat (9) tick();
    pedido = 1'b0;
    wait_idle(400);
    chk("t3_held_at2", 32'(andarAtual), 32'd2);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Fill the FIFO while busy, overflow, then push on the pop cycle
    send(2, 9, 1'b0);
    tick();
    chk("t4_vazia", 32'(fila_vazia), 32'd1);
    for (int i = 0; i < 8; i++) send(i, 11 - i, 1'b0);
    chk("t4_cheia", 32'(fila_cheia), 32'd1);
    chk("t4_ocup8", 32'(ocupacao), 32'd8);
    send(9, 0, 1'b1);
    chk("t4_ocup_ovf", 32'(ocupacao), 32'd8);
    wait_livre(400);
    tick();
    send(10, 1, 1'b0);
    chk("t4_ocup_swap", 32'(ocupacao), 32'd8);
    chk("t4_cheia_swap", 32'(fila_cheia), 32'd1);
    wait_idle(4000);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t4_at1", 32'(andarAtual), 32'd1);

    // Reset while in MOVE_DESTINO at floor 6
    send(1, 8, 1'b0);
    send(3, 4, 1'b0);
    wait_andar(6, 400);
    chk("t5_dir_up", 32'(direcao), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset("t5_rst");
    exp_q.delete();
    origem = 4'd5; destino = 4'd6; pedido = 1'b1;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("t5_held_ocup", 32'(ocupacao), 32'd0);
    chk("t5_held_ocupado", 32'(ocupado), 32'd0);
    pedido = 1'b0;
    tick();
    send(0, 2, 1'b0);
    tick();
    chk("t5_prox0", 32'(proxParada), 32'd0);
    wait_idle(400);
    chk("t5_at2", 32'(andarAtual), 32'd2);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
